// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline buffer: a small circular FIFO carrying register-file and
// HI/LO write-back requests, with flush and NOP-gated outputs when empty.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_W-1:0]            mem_wd,
  input  logic                         mem_wreg,
  input  logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_whilo,
  input  logic [DATA_W-1:0]            mem_hi,
  input  logic [DATA_W-1:0]            mem_lo,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_W-1:0]            wb_wd,
  output logic                         wb_wreg,
  output logic [DATA_W-1:0]            wb_wdata,
  output logic                         wb_whilo,
  output logic [DATA_W-1:0]            wb_hi,
  output logic [DATA_W-1:0]            wb_lo,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + 2 + 3 * DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshake: a side transfers on a cycle where its valid and ready are both
  // high and flush is low. mem_ready and wb_valid depend only on registered
  // occupancy, so neither ready nor valid has a combinational input path.

  logic [ENTRY_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               push;
  logic               pop;

  assign mem_ready = (count < FULL_CNT);
  assign wb_valid  = (count != '0);
  assign occupancy = count;

  assign push = mem_valid && mem_ready && !flush;
  assign pop  = wb_valid && wb_ready && !flush;

  assign wr_entry = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo};

  // Storage is intentionally not reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty buffer presents a NOP: every field, including both write enables, is 0.
  assign rd_entry = wb_valid ? store[rd_ptr] : '0;
  assign {wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo} = rd_entry;

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the write-data, HI and LO fields.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the width of the destination register address.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the number of buffer entries; legal values are powers of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered and incoming entries.
REQ-007 The block SHALL have port mem_valid, input, 1 bit: the MEM-side entry is valid.
REQ-008 The block SHALL have port mem_ready, output, 1 bit: the block accepts an entry this cycle.
REQ-009 The block SHALL have port mem_wd, input, ADDR_W bits: destination register address.
REQ-010 The block SHALL have port mem_wreg, input, 1 bit: register-file write enable.
REQ-011 The block SHALL have port mem_wdata, input, DATA_W bits: register-file write data.
REQ-012 The block SHALL have port mem_whilo, input, 1 bit: HI/LO write enable.
REQ-013 The block SHALL have ports mem_hi and mem_lo, input, DATA_W bits each: HI/LO write data.
REQ-014 The block SHALL have port wb_valid, output, 1 bit: the head entry is present.
REQ-015 The block SHALL have port wb_ready, input, 1 bit: the WB stage consumes the head entry this cycle.
REQ-016 The block SHALL have ports wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi and wb_lo as outputs mirroring the corresponding mem_* widths.
REQ-017 The block SHALL have port occupancy, output, clog2(DEPTH+1) bits: the current entry count.

Function
REQ-018 The block SHALL hold entries in a circular FIFO of DEPTH entries, with read and write pointers wrapping modulo DEPTH.
REQ-019 mem_ready SHALL equal (occupancy < DEPTH), decoded from registered state only, with no combinational path from wb_ready.
REQ-020 A push SHALL occur when mem_valid and mem_ready are both high and flush is low; the entry is written at the write pointer and the pointer advances by 1.
REQ-021 A pop SHALL occur when wb_valid and wb_ready are both high and flush is low; the read pointer advances by 1.
REQ-022 On a simultaneous push and pop, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-023 When full, mem_ready SHALL be 0 and no push SHALL occur, even if a pop happens in the same cycle.
REQ-024 When empty, a pop SHALL NOT occur, and a push SHALL make the entry visible on wb_* in the next cycle (latency of 1 cycle minimum).
REQ-025 wb_valid SHALL equal (occupancy != 0).
REQ-026 When wb_valid is 1, the wb_* fields SHALL show the head entry; when wb_valid is 0, wb_wd, wb_wdata, wb_hi and wb_lo SHALL be 0 and wb_wreg and wb_whilo SHALL be 0 (NOP).
REQ-027 wb_wreg and wb_whilo SHALL be gated by wb_valid, so a write enable is never asserted on an empty buffer.
REQ-028 While wb_valid is high and wb_ready is low, the head entry and all wb_* outputs SHALL remain stable.
REQ-029 When flush is high, on the next edge occupancy and both pointers SHALL return to 0, any push or pop in that cycle SHALL be ignored, and flush SHALL take priority over all other events.
REQ-030 Entries SHALL be delivered strictly in push order, with no loss or duplication.
REQ-031 Storage contents SHALL NOT be reset; only the pointers and occupancy SHALL be reset.

Reset
REQ-032 While rst is 0, asynchronously: occupancy = 0, both pointers = 0, wb_valid = 0, mem_ready = 1, and all wb_* outputs = 0.
REQ-033 Reset asserted mid-operation SHALL discard all entries, and the first entry pushed after release SHALL be the first delivered.
REQ-034 After rst rises, the block SHALL accept a push on the first clock edge.

Verification
REQ-035 Scenario: push {wd=3, wreg=1, wdata=0x12345678} with wb_ready=1 -> next cycle wb_valid=1, wb_wd=3, wb_wdata=0x12345678; one cycle later wb_valid=0.
REQ-036 Scenario: wb_ready=0, push 3 entries with DEPTH=2 -> occupancy=2 and mem_ready=0 after 2 pushes; the third entry is held off; raising wb_ready delivers A, B, C in order.
REQ-037 Scenario: full buffer with a simultaneous push attempt and pop -> occupancy goes to 1 and the pushed entry is not accepted; with occupancy=1, a simultaneous push and pop -> occupancy stays at 1.
REQ-038 Scenario: occupancy=2, flush=1 with mem_valid=1 -> next cycle occupancy=0, wb_valid=0, and the incoming entry is dropped.
REQ-039 Scenario: push {whilo=1, hi=0xAAAA0000, lo=0x0000BBBB, wreg=0} -> wb_whilo=1 with the matching HI/LO values and wb_wreg=0.
REQ-040 Scenario: rst pulled low asynchronously mid-clock-cycle with 2 entries buffered -> immediately occupancy=0 and all wb_* outputs=0; the next push after release is delivered first.
